simon_button_encoder: RTL

Upstream input stage for the Simon sequence stack. Takes four raw, bouncy, asynchronous player buttons and synchronizes and debounces each one. A clean single press becomes one single-cycle `PUSH` pulse with a 2-bit colour code on `DATA_OUT`, wired directly to the stack's `PUSH`/`DATA_IN`. The stack's `FULL` is fed back so that presses arriving while the stack is full are reported as drops rather than pushed.

---
 rtl/simon_button_encoder.sv | 105 ++++++++++
 1 files changed

// File: rtl/simon_button_encoder.sv
// rtl/simon_button_encoder.sv - four-button synchronizer, debouncer and press encoder
// Turns debounced single presses into PUSH pulses with a colour code; chords and full-stack presses become DROP.
module simon_button_encoder #(
   parameter int DATA_WIDTH      = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic [3:0]            BTN,
   input  logic                  FULL,
   output logic                  PUSH,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  DROP,
   output logic                  BUSY
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

   logic [3:0]           sync1_q, sync1_d;
   logic [3:0]           sync2_q, sync2_d;
   logic [3:0]           deb_q, deb_d;
   logic [3:0][CW-1:0]   cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] code;

   state_t                state_q;
   logic                  push_q;
   logic                  drop_q;
   logic [DATA_WIDTH-1:0] data_q;

   always_comb begin
      sync1_d = BTN;
      sync2_d = sync1_q;
      deb_d   = deb_q;
      cnt_d   = '0;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != deb_q[i]) begin
            if (cnt_q[i] == CNT_LAST) begin
               deb_d[i] = ~deb_q[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 1'b1;
            end
         end
      end
   end

   // Only meaningful when deb_q is one-hot; chords never reach DATA_OUT.
   always_comb begin
      code = '0;
      for (int i = 0; i < 4; i++) begin
         if (deb_q[i]) code = DATA_WIDTH'(i);
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         deb_q   <= deb_d;
         cnt_q   <= cnt_d;
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         push_q  <= 1'b0;
         drop_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         push_q <= 1'b0;
         drop_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (deb_q != 4'b0000) begin
                  state_q <= HELD;
                  if ($onehot(deb_q) && !FULL) begin
                     push_q <= 1'b1;
                     data_q <= code;
                  end else begin
                     drop_q <= 1'b1;
                  end
               end
            end
            HELD: begin
               if (deb_q == 4'b0000) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign PUSH     = push_q;
   assign DROP     = drop_q;
   assign DATA_OUT = data_q;
   assign BUSY     = (state_q == HELD);

endmodule
